// File: rtl/cfg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfg_seq_pkg
// Brief    : Shared types and constants for the configuration sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cfg_seq_pkg;

    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4,
        ST_HOLD  = 3'd5
    } cfg_state_e;

endpackage
`default_nettype wire

// File: rtl/cfg_delay_cnt.sv
`default_nettype none
// ============================================================================
// Module   : cfg_delay_cnt
// Brief    : Loadable down-counter; done marks the last cycle of a loaded span.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_delay_cnt
    import cfg_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // A load of N yields N cycles, with done on the N-th.
    assign done = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/cfg_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cfg_seq_ctrl
// Brief    : Sequences single host config reads/writes onto the CGRA config
//            chain, holding the array stalled for the whole burst.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_seq_ctrl
    import cfg_seq_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int STALL_SETUP = 2,
    parameter int READ_LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] config_config_addr,
    output logic [DATA_W-1:0] config_config_data,
    output logic              config_write,
    output logic              config_read,
    input  logic [DATA_W-1:0] read_config_data,
    output logic              stall,
    output logic              busy
);

    localparam logic [CNT_W-1:0] c_setup_cnt = CNT_W'(STALL_SETUP);
    localparam logic [CNT_W-1:0] c_read_cnt  = CNT_W'(READ_LAT);

    generate
        if (STALL_SETUP < 1 || STALL_SETUP > CNT_MAX) begin : g_bad_stall_setup
            $error("cfg_seq_ctrl: STALL_SETUP must be in 1..15");
        end
        if (READ_LAT < 1 || READ_LAT > CNT_MAX) begin : g_bad_read_lat
            $error("cfg_seq_ctrl: READ_LAT must be in 1..15");
        end
    endgenerate

    cfg_state_e        r_state;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic              w_req_fire;
    logic              w_cnt_load;
    logic              w_cnt_done;
    logic [CNT_W-1:0]  w_cnt_val;

    assign w_req_fire = req_valid && req_ready;

    // One counter serves both the stall setup span and the read latency span.
    assign w_cnt_load = ((r_state == ST_IDLE) && w_req_fire) ||
                        ((r_state == ST_ISSUE) && !r_write);
    assign w_cnt_val  = (r_state == ST_IDLE) ? c_setup_cnt : c_read_cnt;

    cfg_delay_cnt u_delay_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_cnt_load),
        .load_val (w_cnt_val),
        .done     (w_cnt_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= ST_IDLE;
            r_write            <= 1'b0;
            r_addr             <= '0;
            r_data             <= '0;
            req_ready          <= 1'b0;
            resp_valid         <= 1'b0;
            resp_data          <= '0;
            config_config_addr <= '0;
            config_config_data <= '0;
            config_write       <= 1'b0;
            config_read        <= 1'b0;
            stall              <= 1'b0;
            busy               <= 1'b0;
        end else begin
            // Strobes and chain address/data live for the ISSUE cycle only.
            config_write       <= 1'b0;
            config_read        <= 1'b0;
            config_config_addr <= '0;
            config_config_data <= '0;

            case (r_state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (w_req_fire) begin
                        r_write   <= req_write;
                        r_addr    <= req_addr;
                        r_data    <= req_data;
                        r_state   <= ST_SETUP;
                        req_ready <= 1'b0;
                        stall     <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (w_cnt_done) begin
                        r_state            <= ST_ISSUE;
                        config_write       <= r_write;
                        config_read        <= !r_write;
                        config_config_addr <= r_addr;
                        config_config_data <= r_write ? r_data : '0;
                    end
                end
                ST_ISSUE: begin
                    if (r_write) begin
                        r_state   <= ST_HOLD;
                        req_ready <= 1'b1;
                    end else begin
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_cnt_done) begin
                        r_state    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= read_config_data;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state    <= ST_HOLD;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Array is still stalled, so a follow-on request skips setup.
                    if (w_req_fire) begin
                        r_write            <= req_write;
                        r_addr             <= req_addr;
                        r_data             <= req_data;
                        r_state            <= ST_ISSUE;
                        req_ready          <= 1'b0;
                        config_write       <= req_write;
                        config_read        <= !req_write;
                        config_config_addr <= req_addr;
                        config_config_data <= req_write ? req_data : '0;
                    end else begin
                        r_state <= ST_IDLE;
                        stall   <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    req_ready  <= 1'b0;
                    resp_valid <= 1'b0;
                    stall      <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cfg_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_seq_ctrl
// Brief    : Self-checking bench for cfg_seq_ctrl with an emulated config array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_seq_ctrl;

    localparam int SETUP = 2;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [31:0] config_config_addr;
    logic [31:0] config_config_data;
    logic        config_write;
    logic        config_read;
    logic [31:0] read_config_data = '0;
    logic        stall;
    logic        busy;

    cfg_seq_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STALL_SETUP (SETUP),
        .READ_LAT    (LAT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_addr           (req_addr),
        .req_data           (req_data),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_data          (resp_data),
        .config_config_addr (config_config_addr),
        .config_config_data (config_config_data),
        .config_write       (config_write),
        .config_read        (config_read),
        .read_config_data   (read_config_data),
        .stall              (stall),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Per-cycle history of DUT outputs, indexed by cycle number.
    logic        h_stall [int];
    logic        h_ready [int];
    logic        h_rv    [int];
    logic        h_wr    [int];
    logic        h_rs    [int];
    logic        h_busy  [int];
    logic [31:0] h_addr  [int];
    logic [31:0] h_data  [int];
    logic [31:0] h_rd    [int];

    int n_leak = 0, n_busy_mis = 0, n_wr_stb = 0, n_rd_stb = 0;

    logic [31:0] arr_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          rd_due = -1;
    logic [31:0] rd_val = '0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Advance one cycle, log outputs, and play the array's side of the chain.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        h_stall[cyc] = stall;
        h_ready[cyc] = req_ready;
        h_rv[cyc]    = resp_valid;
        h_wr[cyc]    = config_write;
        h_rs[cyc]    = config_read;
        h_busy[cyc]  = busy;
        h_addr[cyc]  = config_config_addr;
        h_data[cyc]  = config_config_data;
        h_rd[cyc]    = resp_data;
        if (!config_write && !config_read &&
            (config_config_addr !== '0 || config_config_data !== '0)) n_leak++;
        if (config_read === 1'b1 && config_config_data !== '0) n_leak++;
        if (config_write === 1'b1 && config_read === 1'b1) n_leak++;
        if (busy !== stall) n_busy_mis++;
        if (config_write === 1'b1) begin
            n_wr_stb++;
            arr_mem[config_config_addr] = config_config_data;
        end
        if (config_read === 1'b1) begin
            n_rd_stb++;
            rd_due = cyc + LAT;
            rd_val = arr_mem.exists(config_config_addr) ? arr_mem[config_config_addr]
                                                        : dflt(config_config_addr);
        end
        read_config_data = (cyc == rd_due) ? rd_val : $urandom();
    endtask

    // Present a request until accepted; t is the handshake cycle or -1.
    task automatic send_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output int t);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        t = -1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready === 1'b1) begin
                t = cyc;
                break;
            end
            step();
        end
        step();
        req_valid = 1'b0;
        req_addr  = $urandom();
        req_data  = $urandom();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({req_ready, resp_valid, config_write, config_read, stall, busy} !== 6'b0)
            begin n_fail++; $display("FAIL reset_ctrl: got %b required 000000",
                {req_ready, resp_valid, config_write, config_read, stall, busy}); end
        n_checks++;
        if (resp_data !== '0 || config_config_addr !== '0 || config_config_data !== '0)
            begin n_fail++; $display("FAIL reset_buses: resp %h addr %h data %h required 0",
                resp_data, config_config_addr, config_config_data); end
        reset = 1'b1;
        step();
        n_checks++;
        if (req_ready !== 1'b1)
            begin n_fail++; $display("FAIL reset_release_ready: got %b required 1", req_ready); end
        n_checks++;
        if (stall !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL reset_release_stall: stall %b busy %b required 0", stall, busy); end
    endtask

    task automatic test_single_write();
        int t, iss, bad;
        resp_ready = 1'b1;
        ref_mem[32'h0000_0104] = 32'hDEAD_BEEF;
        send_req(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, t);
        n_checks++;
        if (t < 0) begin n_fail++; $display("FAIL wr_handshake: got none required accept"); return; end
        iss = t + 1 + SETUP;
        while (cyc < iss + 2) step();
        bad = 0;
        for (int c = t + 1; c <= iss + 1; c++) if (h_stall[c] !== 1'b1) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL wr_stall_window: %0d low cycles required 0", bad); end
        n_checks++;
        if (h_stall[iss+2] !== 1'b0 || h_busy[iss+2] !== 1'b0)
            begin n_fail++; $display("FAIL wr_idle: stall %b busy %b required 0", h_stall[iss+2], h_busy[iss+2]); end
        n_checks++;
        if (h_wr[iss] !== 1'b1 || h_rs[iss] !== 1'b0)
            begin n_fail++; $display("FAIL wr_strobe: wr %b rd %b required 1/0", h_wr[iss], h_rs[iss]); end
        n_checks++;
        if (h_addr[iss] !== 32'h0000_0104 || h_data[iss] !== 32'hDEAD_BEEF)
            begin n_fail++; $display("FAIL wr_addr_data: %h/%h required 00000104/deadbeef", h_addr[iss], h_data[iss]); end
        bad = 0;
        for (int c = t + 1; c <= iss + 2; c++)
            if (c != iss && (h_wr[c] !== 1'b0 || h_rs[c] !== 1'b0)) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL wr_extra_strobe: %0d extra required 0", bad); end
        bad = 0;
        for (int c = t + 1; c <= iss + 2; c++) if (h_rv[c] !== 1'b0) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL wr_no_resp: %0d resp cycles required 0", bad); end
        bad = 0;
        for (int c = t + 1; c <= iss; c++) if (h_ready[c] !== 1'b0) bad++;
        n_checks++;
        if (bad != 0 || h_ready[iss+1] !== 1'b1 || h_ready[iss+2] !== 1'b1)
            begin n_fail++; $display("FAIL wr_ready: busy-ready %0d hold %b idle %b required 0/1/1",
                bad, h_ready[iss+1], h_ready[iss+2]); end
    endtask

    task automatic test_single_read();
        int t, iss, rsp, bad;
        arr_mem[32'h0000_0208] = 32'h1234_5678;
        ref_mem[32'h0000_0208] = 32'h1234_5678;
        resp_ready = 1'b1;
        send_req(1'b0, 32'h0000_0208, 32'hFFFF_FFFF, t);
        n_checks++;
        if (t < 0) begin n_fail++; $display("FAIL rd_handshake: got none required accept"); return; end
        iss = t + 1 + SETUP;
        rsp = iss + LAT + 1;
        while (cyc < rsp + 2) step();
        n_checks++;
        if (h_rs[iss] !== 1'b1 || h_wr[iss] !== 1'b0 || h_addr[iss] !== 32'h0000_0208 || h_data[iss] !== '0)
            begin n_fail++; $display("FAIL rd_strobe: rd %b wr %b addr %h data %h required 1/0/208/0",
                h_rs[iss], h_wr[iss], h_addr[iss], h_data[iss]); end
        bad = 0;
        for (int c = t + 1; c < rsp; c++) if (h_rv[c] !== 1'b0) bad++;
        n_checks++;
        if (bad != 0 || h_rv[rsp] !== 1'b1)
            begin n_fail++; $display("FAIL rd_resp_time: early %0d at_rsp %b required 0/1", bad, h_rv[rsp]); end
        n_checks++;
        if (h_rd[rsp] !== exp_rd(32'h0000_0208))
            begin n_fail++; $display("FAIL rd_data: got %h required %h", h_rd[rsp], exp_rd(32'h0000_0208)); end
        n_checks++;
        if (h_rv[rsp+1] !== 1'b0 || h_stall[rsp+1] !== 1'b1 || h_ready[rsp+1] !== 1'b1)
            begin n_fail++; $display("FAIL rd_hold: rv %b stall %b ready %b required 0/1/1",
                h_rv[rsp+1], h_stall[rsp+1], h_ready[rsp+1]); end
        n_checks++;
        if (h_stall[rsp+2] !== 1'b0)
            begin n_fail++; $display("FAIL rd_idle: stall %b required 0", h_stall[rsp+2]); end
    endtask

    task automatic test_back_to_back();
        int t1, t2, bad;
        resp_ready = 1'b1;
        ref_mem[32'h0000_0300] = 32'hA5A5_0001;
        ref_mem[32'h0000_0304] = 32'h5A5A_0002;
        send_req(1'b1, 32'h0000_0300, 32'hA5A5_0001, t1);
        send_req(1'b1, 32'h0000_0304, 32'h5A5A_0002, t2);
        n_checks++;
        if (t1 < 0 || t2 != t1 + 2 + SETUP)
            begin n_fail++; $display("FAIL b2b_accept: t2-t1 %0d required %0d", t2 - t1, 2 + SETUP); return; end
        while (cyc < t2 + 3) step();
        n_checks++;
        if (h_wr[t1+1+SETUP] !== 1'b1 || h_wr[t2+1] !== 1'b1 || h_wr[t2] !== 1'b0)
            begin n_fail++; $display("FAIL b2b_strobes: %b %b %b required 1 0 1",
                h_wr[t1+1+SETUP], h_wr[t2], h_wr[t2+1]); end
        n_checks++;
        if (h_addr[t2+1] !== 32'h0000_0304 || h_data[t2+1] !== 32'h5A5A_0002)
            begin n_fail++; $display("FAIL b2b_addr_data: %h/%h required 00000304/5a5a0002",
                h_addr[t2+1], h_data[t2+1]); end
        bad = 0;
        for (int c = t1 + 1; c <= t2 + 2; c++) if (h_stall[c] !== 1'b1) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL b2b_stall_gap: %0d low cycles required 0", bad); end
        n_checks++;
        if (h_stall[t2+3] !== 1'b0)
            begin n_fail++; $display("FAIL b2b_idle: stall %b required 0", h_stall[t2+3]); end
    endtask

    task automatic test_resp_backpressure();
        int t, rsp, bad;
        logic [31:0] exp;
        exp = exp_rd(32'h0000_040C);
        resp_ready = 1'b0;
        send_req(1'b0, 32'h0000_040C, 32'h0, t);
        n_checks++;
        if (t < 0) begin n_fail++; $display("FAIL bp_handshake: got none required accept"); return; end
        rsp = t + 1 + SETUP + LAT + 1;
        while (cyc < rsp + 3) step();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        step();
        bad = 0;
        for (int c = rsp; c <= rsp + 3; c++)
            if (h_rv[c] !== 1'b1 || h_rd[c] !== exp) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL bp_resp_held: %0d bad cycles required 0 (data %h)", bad, exp); end
        bad = 0;
        for (int c = rsp; c <= rsp + 3; c++)
            if (h_stall[c] !== 1'b1 || h_ready[c] !== 1'b0) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL bp_stall_ready: %0d bad cycles required 0", bad); end
        n_checks++;
        if (h_rv[rsp+4] !== 1'b0 || h_ready[rsp+4] !== 1'b1 || h_stall[rsp+4] !== 1'b1)
            begin n_fail++; $display("FAIL bp_accept: rv %b ready %b stall %b required 0/1/1",
                h_rv[rsp+4], h_ready[rsp+4], h_stall[rsp+4]); end
        n_checks++;
        if (h_stall[rsp+5] !== 1'b0)
            begin n_fail++; $display("FAIL bp_idle: stall %b required 0", h_stall[rsp+5]); end
    endtask

    task automatic test_reset_in_wait();
        int t, iss, rsp, bad, stb0;
        logic [31:0] exp;
        resp_ready = 1'b1;
        send_req(1'b0, 32'h0000_0500, 32'h0, t);
        n_checks++;
        if (t < 0) begin n_fail++; $display("FAIL rw_handshake: got none required accept"); return; end
        iss = t + 1 + SETUP;
        while (cyc < iss + 1) step();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, resp_valid, config_write, config_read, stall, busy} !== 6'b0 ||
            config_config_addr !== '0 || config_config_data !== '0)
            begin n_fail++; $display("FAIL rw_async_clear: ctrl %b addr %h data %h required 0",
                {req_ready, resp_valid, config_write, config_read, stall, busy},
                config_config_addr, config_config_data); end
        step();
        step();
        reset = 1'b1;
        step();
        n_checks++;
        if (req_ready !== 1'b1 || stall !== 1'b0)
            begin n_fail++; $display("FAIL rw_release: ready %b stall %b required 1/0", req_ready, stall); end
        stb0 = n_wr_stb + n_rd_stb;
        bad = 0;
        repeat (6) begin
            step();
            if (resp_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || n_wr_stb + n_rd_stb != stb0)
            begin n_fail++; $display("FAIL rw_no_stale: resp %0d strobes %0d required 0/0",
                bad, n_wr_stb + n_rd_stb - stb0); end
        exp = exp_rd(32'h0000_0504);
        send_req(1'b0, 32'h0000_0504, 32'h0, t);
        rsp = t + 1 + SETUP + LAT + 1;
        while (cyc < rsp + 1) step();
        n_checks++;
        if (t < 0 || h_rv[rsp] !== 1'b1 || h_rd[rsp] !== exp)
            begin n_fail++; $display("FAIL rw_next_read: rv %b data %h required 1/%h",
                h_rv[rsp], h_rd[rsp], exp); end
    endtask

    task automatic test_random();
        int t, iss, first, gap;
        logic wr, acc, from_idle;
        logic [31:0] a, d, exp, got;
        for (int k = 0; k < 40; k++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = 32'h0000_0700 + ($urandom_range(0, 7) << 2);
            d   = $urandom();
            gap = $urandom_range(0, 3);
            repeat (gap) step();
            send_req(wr, a, d, t);
            if (t < 0) begin
                n_checks++; n_fail++;
                $display("FAIL rand_accept: txn %0d got none required accept", k);
                return;
            end
            from_idle = (h_busy[t] === 1'b0);
            iss = from_idle ? t + 1 + SETUP : t + 1;
            while (cyc < iss) step();
            n_checks++;
            if (h_wr[iss] !== wr || h_rs[iss] !== !wr || h_addr[iss] !== a)
                begin n_fail++; $display("FAIL rand_strobe: txn %0d wr %b rd %b addr %h required %b/%b/%h",
                    k, h_wr[iss], h_rs[iss], h_addr[iss], wr, !wr, a); end
            if (wr) begin
                ref_mem[a] = d;
                n_checks++;
                if (h_data[iss] !== d)
                    begin n_fail++; $display("FAIL rand_wdata: txn %0d got %h required %h", k, h_data[iss], d); end
            end else begin
                exp   = exp_rd(a);
                first = -1;
                acc   = 1'b0;
                got   = '0;
                for (int i = 0; i < 60 && !acc; i++) begin
                    resp_ready = ($urandom_range(0, 3) != 0);
                    if (resp_valid === 1'b1 && first < 0) first = cyc;
                    if (resp_valid === 1'b1 && resp_ready) begin
                        got = resp_data;
                        acc = 1'b1;
                    end
                    step();
                end
                n_checks++;
                if (first != iss + LAT + 1)
                    begin n_fail++; $display("FAIL rand_resp_time: txn %0d got %0d required %0d", k, first, iss + LAT + 1); end
                n_checks++;
                if (!acc || got !== exp)
                    begin n_fail++; $display("FAIL rand_rdata: txn %0d got %h required %h", k, got, exp); end
            end
        end
        repeat (3) step();
    endtask

    task automatic test_invariants();
        n_checks++;
        if (n_leak != 0)
            begin n_fail++; $display("FAIL chain_bus_idle: %0d violations required 0", n_leak); end
        n_checks++;
        if (n_busy_mis != 0)
            begin n_fail++; $display("FAIL busy_vs_stall: %0d mismatching cycles required 0", n_busy_mis); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_resp_backpressure();
        test_reset_in_wait();
        test_random();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
